// File: rtl/game_referee.sv
`default_nettype none
// ============================================================================
//  Module   : game_referee
//  Purpose  : N x N k-in-a-row referee. Holds the board, validates moves
//             offered over a valid/ready handshake (range, occupancy, turn),
//             then walks the four lines through the new cell one cell per
//             cycle to detect a win or draw.
//  Ports    : clk, rst_n (sync, active low), new_game (sync clear)
//             move_valid/move_ready   move handshake
//             move_row/move_col/move_player   move payload
//             move_ack/move_err       one-cycle result pulses
//             err_code                last rejection cause (sticky)
//             board_flat              2 bits per cell, 0=P1 1=P2 2=empty
//             turn, move_count, who_won   game status
//  Revision : 1.0  initial release
// ============================================================================
module game_referee #(
    parameter int N = 3,
    parameter int K = 3,
    localparam int RW = $clog2(N),
    localparam int CW = $clog2(N*N+1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            new_game,
    input  logic            move_valid,
    output logic            move_ready,
    input  logic [RW-1:0]   move_row,
    input  logic [RW-1:0]   move_col,
    input  logic            move_player,
    output logic            move_ack,
    output logic            move_err,
    output logic [1:0]      err_code,
    output logic [2*N*N-1:0] board_flat,
    output logic            turn,
    output logic [CW-1:0]   move_count,
    output logic [1:0]      who_won
);
    localparam int SW   = RW + 2;
    localparam int IW   = $clog2(N*N);
    localparam int RUNW = $clog2(2*K);

    localparam logic signed [SW-1:0] c_n_s    = SW'(N);
    localparam logic signed [SW-1:0] c_km1    = SW'(K-1);
    localparam logic [RW:0]          c_n_u    = (RW+1)'(N);
    localparam logic [IW-1:0]        c_n_idx  = IW'(N);
    localparam logic [CW-1:0]        c_cells  = CW'(N*N);
    localparam logic [RUNW-1:0]      c_k_run  = RUNW'(K);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    state_t                  r_state, w_state_next;
    logic [2*N*N-1:0]        r_board;
    logic                    r_turn;
    logic [CW-1:0]           r_count;
    logic [1:0]              r_who;
    logic                    r_ack, r_err;
    logic [1:0]              r_err_code;
    logic [RW-1:0]           r_row, r_col;
    logic                    r_player;
    logic [1:0]              r_dir;
    logic signed [SW-1:0]    r_off;
    logic [RUNW-1:0]         r_run;
    logic                    r_win;
    logic                    r_done;

    logic                    w_clear, w_accept, w_in_range;
    logic [IW-1:0]           w_mv_idx, w_scan_idx;
    logic [1:0]              w_mv_cell, w_scan_cell, w_err_code;
    logic signed [SW-1:0]    w_row_s, w_col_s, w_off_r, w_off_c, w_pr, w_pc;
    logic                    w_inb, w_hit, w_dir_end;
    logic [RUNW-1:0]         w_run_next;

    assign w_clear = !rst_n || new_game;

    // ---------------- move validation ----------------
    always_comb begin
        w_accept   = move_valid && (r_state == S_IDLE);
        w_in_range = ({1'b0, move_row} < c_n_u) && ({1'b0, move_col} < c_n_u);
        w_mv_idx   = IW'(move_row) * c_n_idx + IW'(move_col);
        w_mv_cell  = r_board[{w_mv_idx, 1'b0} +: 2];
        w_err_code = 2'd0;
        if (!w_in_range)
            w_err_code = 2'd1;
        else if (w_mv_cell != 2'b10)
            w_err_code = 2'd2;
        else if (move_player != r_turn)
            w_err_code = 2'd3;
    end

    // ---------------- scan position ----------------
    // Directions: 0 -> (0,1), 1 -> (1,0), 2 -> (1,1), 3 -> (1,-1).
    always_comb begin
        w_row_s = $signed({2'b00, r_row});
        w_col_s = $signed({2'b00, r_col});
        case (r_dir)
            2'd0:    begin w_off_r = '0;    w_off_c = r_off;  end
            2'd1:    begin w_off_r = r_off; w_off_c = '0;     end
            2'd2:    begin w_off_r = r_off; w_off_c = r_off;  end
            default: begin w_off_r = r_off; w_off_c = -r_off; end
        endcase
        w_pr = w_row_s + w_off_r;
        w_pc = w_col_s + w_off_c;
        // Sign bit clear means non-negative; only then is the board read used.
        w_inb = !w_pr[SW-1] && (w_pr < c_n_s) && !w_pc[SW-1] && (w_pc < c_n_s);
        w_scan_idx  = IW'(w_pr[RW-1:0]) * c_n_idx + IW'(w_pc[RW-1:0]);
        w_scan_cell = r_board[{w_scan_idx, 1'b0} +: 2];
        w_hit       = w_inb && (w_scan_cell == {1'b0, r_player});
        w_run_next  = w_hit ? r_run + 1'b1 : '0;
        w_dir_end   = (r_off == c_km1);
    end

    // ---------------- next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_err_code == 2'd0))
                    w_state_next = S_CHECK;
            end
            S_CHECK: begin
                if (r_done) begin
                    if (r_win || ((r_count + 1'b1) == c_cells))
                        w_state_next = S_OVER;
                    else
                        w_state_next = S_IDLE;
                end
            end
            S_OVER:  w_state_next = S_OVER;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_board    <= {(N*N){2'b10}};
            r_turn     <= 1'b0;
            r_count    <= '0;
            r_who      <= 2'd3;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_row      <= '0;
            r_col      <= '0;
            r_player   <= 1'b0;
            r_dir      <= 2'd0;
            r_off      <= '0;
            r_run      <= '0;
            r_win      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (w_accept) begin
                if (w_err_code != 2'd0) begin
                    r_err      <= 1'b1;
                    r_err_code <= w_err_code;
                end else begin
                    r_board[{w_mv_idx, 1'b0} +: 2] <= {1'b0, move_player};
                    r_row    <= move_row;
                    r_col    <= move_col;
                    r_player <= move_player;
                    r_dir    <= 2'd0;
                    r_off    <= -c_km1;
                    r_run    <= '0;
                    r_win    <= 1'b0;
                    r_done   <= 1'b0;
                end
            end else if (r_state == S_CHECK) begin
                if (r_done) begin
                    r_ack   <= 1'b1;
                    r_count <= r_count + 1'b1;
                    r_turn  <= ~r_turn;
                    if (r_win)
                        r_who <= {1'b0, r_player};
                    else if ((r_count + 1'b1) == c_cells)
                        r_who <= 2'd2;
                end else begin
                    if (w_run_next >= c_k_run)
                        r_win <= 1'b1;
                    if (w_dir_end) begin
                        // Next direction starts with a fresh run.
                        r_run <= '0;
                        r_off <= -c_km1;
                        r_dir <= r_dir + 1'b1;
                        if (r_dir == 2'd3)
                            r_done <= 1'b1;
                    end else begin
                        r_run <= w_run_next;
                        r_off <= r_off + 1'b1;
                    end
                end
            end
        end
    end

    assign move_ready = (r_state == S_IDLE);
    assign move_ack   = r_ack;
    assign move_err   = r_err;
    assign err_code   = r_err_code;
    assign board_flat = r_board;
    assign turn       = r_turn;
    assign move_count = r_count;
    assign who_won    = r_who;

endmodule
`default_nettype wire

// File: doc/game_referee.md
# game_referee

Parametrised tic-tac-toe / k-in-a-row referee. It holds the N×N board and accepts player moves over a valid/ready handshake. Each move is validated for range, occupancy and turn order. After each accepted move, a fixed-latency sequential scan checks the four lines through the new cell and updates the game result. It supersedes the separate 3×3 board-state and winner-detect logic: the display and player-input blocks read the board and result from this block.

## Interface
Parameters:
- N, 3, board side length; legal range 3..8.
- K, 3, run length needed to win; legal range 3..N.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- new_game  in  1  synchronous game clear; same effect as reset.
- move_valid  in  1  a move is presented.
- move_ready  out  1  the block can accept a move.
- move_row  in  RW=$clog2(N)  target row.
- move_col  in  RW  target column.
- move_player  in  1  0 = player 1, 1 = player 2.
- move_ack  out  1  one-cycle pulse: move committed and result updated.
- move_err  out  1  one-cycle pulse: move rejected.
- err_code  out  2  1 = out of range, 2 = cell occupied, 3 = wrong turn; holds its value until the next error or clear.
- board_flat  out  2*N*N  cell (r,c) occupies bits [2(rN+c)+1 : 2(rN+c)]; 0 = P1, 1 = P2, 2 = empty.
- turn  out  1  player expected next.
- move_count  out  $clog2(N*N+1)  number of committed moves.
- who_won  out  2  0 = P1 won, 1 = P2 won, 2 = draw, 3 = in progress.

## Operation
- Reset value (rst_n=0 or new_game=1 at an edge):
  - All cells are 2, turn=0, move_count=0, who_won=3.
  - move_ack=0, move_err=0, err_code=0, state IDLE.
  - move_ready goes to 1 at the next edge.
- new_game overrides every other activity, including an in-progress scan. An aborted move produces no ack.
- States:
  - IDLE: move_ready=1.
  - CHECK: move_ready=0.
  - OVER: move_ready=0; leaves only on new_game or reset.
- Acceptance: a move is taken at an edge where move_valid && move_ready.
- Validation is combinational at acceptance, with priority out-of-range > occupied > wrong turn (move_player != turn).
  - Error: move_err pulses and err_code is set at that edge. The board is unchanged and the state stays IDLE.
  - Valid: the cell is written with move_player, (row, col, player) is latched, and the state goes to CHECK.
- Scan: directions d = 0..3 are (0,1), (1,0), (1,1), (1,-1).
  - For each direction, offset o runs from -(K-1) to K-1. That is L = 4(2K-1) steps, one per cycle.
  - The position is (row+o·dr, col+o·dc). An in-bounds cell equal to player increments the run counter; anything else clears it.
  - The run counter clears at each direction start. A run reaching K sets a sticky win flag.
  - The scan always runs the full L steps; there is no early exit.
- After the scan:
  - move_count increments and turn toggles.
  - Win: who_won = player, go to OVER.
  - Otherwise, if move_count == N*N: who_won = 2, go to OVER.
  - Otherwise: go to IDLE.
- Coordinate arithmetic is signed, width RW+2, with a bounds check of 0..N-1 before any board read.

## Timing
- Acceptance at edge A: the cell is visible on board_flat and move_ready=0 from A.
- Scan steps occur at edges A+1 .. A+L.
- At edge A+L+1:
  - move_ack=1 for one cycle.
  - who_won, turn and move_count update together.
  - move_ready returns to 1 if the game is not over.
- For N=K=3: L=20, so the ack comes at A+21.
- An error has 1-cycle turnaround: move_err is high in the cycle after the edge, and move_ready stays 1 throughout.
- move_valid held high while move_ready=0 is ignored, and no error is raised.

## Test plan
- Reset: rst_n low for 2 cycles -> board_flat all cells 2, who_won=3, turn=0, move_count=0, move_ready=1.
- Row win, N=K=3: P1(0,0), P2(1,0), P1(0,1), P2(1,1), P1(0,2) -> each ack exactly 21 cycles after acceptance; who_won=0 after the 5th move; move_ready stays 0; a 6th move_valid is ignored.
- Anti-diagonal win, N=4, K=3: P2 wins at (0,3), (1,2), (2,1) -> who_won=1. A run of 2 in a row does not win.
- Errors:
  - (3,0) on N=3 -> err_code=1.
  - Replaying an occupied cell -> err_code=2.
  - P2 moving on P1's turn -> err_code=3.
  - In every case: board_flat, turn and move_count unchanged, no ack.
- Draw, N=K=3, full board with no line: sequence P1(0,0), P2(0,1), P1(0,2), P2(1,1), P1(1,0), P2(1,2), P1(2,1), P2(2,0), P1(2,2) -> who_won=2 and move_count=9 after the 9th ack.
- new_game asserted 5 cycles into a scan -> no ack; next edge shows all cells 2, who_won=3, turn=0, move_ready=1.
